// File: rtl/note_hit_judge.sv
// Per-lane hit judge: synchronizes the player's key, tracks the lane's falling note, and scores hits/misses.
// Optional build macro JUDGE_STREAK_MULT_EN enables streak-based point multipliers.
module note_hit_judge #(
    parameter logic [9:0]  HIT_LINE   = 10'd440,
    parameter logic [9:0]  WINDOW     = 10'd12,
    parameter logic [9:0]  NOTE_SIZE  = 10'd40,
    parameter logic [15:0] HIT_POINTS = 16'd10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  note_y_pos,
    input  logic        note_valid,
    input  logic        key_press,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        note_clear,
    output logic [15:0] score,
    output logic [7:0]  streak
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_JUDGED = 2'd2;

    localparam logic [10:0] WIN_LO = {1'b0, HIT_LINE} - {1'b0, WINDOW};
    localparam logic [10:0] WIN_HI = {1'b0, HIT_LINE} + {1'b0, WINDOW};

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        prev_q, prev_d;
    logic [1:0]  state_q, state_d;
    logic        hit_q, hit_d;
    logic        miss_q, miss_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  streak_q, streak_d;

    logic        key_rise_s;
    logic [10:0] bottom_s;
    logic        in_window_s;
    logic        late_s;
    logic [16:0] pts_s;
    logic [16:0] score_sum_s;
    logic [15:0] score_inc_s;
    logic [7:0]  streak_inc_s;

    // Key synchronizer and edge history next-state.
    always_comb begin
        s1_d       = key_press;
        s2_d       = s1_q;
        prev_d     = s2_q;
        key_rise_s = s2_q & ~prev_q;
    end

    // Note geometry against the strike line, 11 bits so the bottom edge never wraps.
    always_comb begin
        bottom_s    = {1'b0, note_y_pos} + {1'b0, NOTE_SIZE};
        in_window_s = (bottom_s >= WIN_LO) && (bottom_s <= WIN_HI);
        late_s      = (bottom_s > WIN_HI);
    end

    // Points for a hit, scaled by the streak held before this hit when the multiplier is built in.
    always_comb begin
`ifdef JUDGE_STREAK_MULT_EN
        if (streak_q >= 8'd30) begin
            pts_s = {1'b0, HIT_POINTS} << 2'd2;
        end else if (streak_q >= 8'd10) begin
            pts_s = {1'b0, HIT_POINTS} << 2'd1;
        end else begin
            pts_s = {1'b0, HIT_POINTS};
        end
`else
        pts_s = {1'b0, HIT_POINTS};
`endif
    end

    // Saturating score and streak increments.
    always_comb begin
        score_sum_s  = {1'b0, score_q} + pts_s;
        score_inc_s  = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        streak_inc_s = (streak_q == 8'hFF) ? 8'hFF : (streak_q + 8'd1);
    end

    // Judge FSM: at most one hit or miss per note between visits to IDLE.
    always_comb begin
        state_d  = state_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        score_d  = score_q;
        streak_d = streak_q;
        case (state_q)
            ST_IDLE: begin
                if (note_valid) begin
                    state_d = late_s ? ST_JUDGED : ST_TRACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRACK: begin
                // A disappearing note wins over a simultaneous strum; a strum wins over lateness.
                if (!note_valid) begin
                    state_d = ST_IDLE;
                end else if (key_rise_s) begin
                    state_d = ST_JUDGED;
                    if (in_window_s) begin
                        hit_d    = 1'b1;
                        score_d  = score_inc_s;
                        streak_d = streak_inc_s;
                    end else begin
                        miss_d   = 1'b1;
                        streak_d = 8'd0;
                    end
                end else if (late_s) begin
                    state_d  = ST_JUDGED;
                    miss_d   = 1'b1;
                    streak_d = 8'd0;
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_JUDGED: begin
                if (!note_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_JUDGED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= ST_IDLE;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= 16'd0;
            streak_q <= 8'd0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            streak_q <= streak_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign note_clear = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign streak     = streak_q;

endmodule

// File: tb/tb_note_hit_judge.sv
// Self-checking bench for note_hit_judge: directed scenarios then random play against a reference model.
module tb_note_hit_judge;

    logic        Clk;
    logic        Reset;
    logic [9:0]  note_y_pos;
    logic        note_valid;
    logic        key_press;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        note_clear;
    logic [15:0] score;
    logic [7:0]  streak;

    int errors = 0;
    int checks = 0;

    // Reference model: key samples per edge, note phase (0 none, 1 live, 2 done), and counters.
    int m_key [0:2];
    int m_phase;
    int m_score;
    int m_streak;
    int m_hit;
    int m_miss;
    int hits_seen;
    int miss_seen;

    note_hit_judge dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .note_y_pos (note_y_pos),
        .note_valid (note_valid),
        .key_press  (key_press),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .note_clear (note_clear),
        .score      (score),
        .streak     (streak)
    );

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_key[0] = 0;
        m_key[1] = 0;
        m_key[2] = 0;
        m_phase  = 0;
        m_score  = 0;
        m_streak = 0;
        m_hit    = 0;
        m_miss   = 0;
    endtask

    function automatic int pts_for(input int strk);
`ifdef JUDGE_STREAK_MULT_EN
        if (strk >= 30) return 40;
        if (strk >= 10) return 20;
        return 10;
`else
        return 10;
`endif
    endfunction

    // One clock edge of the game rules, using the inputs present at that edge.
    task automatic model_edge(input int v, input int y, input int k);
        int bottom;
        int rise;
        bottom = y + 40;
        rise   = (m_key[1] == 1 && m_key[2] == 0) ? 1 : 0;
        m_hit  = 0;
        m_miss = 0;
        if (m_phase == 0) begin
            if (v != 0) m_phase = (bottom > 452) ? 2 : 1;
        end else if (m_phase == 1) begin
            if (v == 0) begin
                m_phase = 0;
            end else if (rise == 1) begin
                m_phase = 2;
                if (bottom >= 428 && bottom <= 452) begin
                    m_hit    = 1;
                    m_score  = (m_score + pts_for(m_streak) > 65535) ? 65535 : m_score + pts_for(m_streak);
                    m_streak = (m_streak == 255) ? 255 : m_streak + 1;
                end else begin
                    m_miss   = 1;
                    m_streak = 0;
                end
            end else if (bottom > 452) begin
                m_phase  = 2;
                m_miss   = 1;
                m_streak = 0;
            end
        end else begin
            if (v == 0) m_phase = 0;
        end
        m_key[2] = m_key[1];
        m_key[1] = m_key[0];
        m_key[0] = k;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".hit"},    int'(hit_pulse),  m_hit);
        check({tag, ".miss"},   int'(miss_pulse), m_miss);
        check({tag, ".clear"},  int'(note_clear), m_hit);
        check({tag, ".score"},  int'(score),      m_score);
        check({tag, ".streak"}, int'(streak),     m_streak);
        check({tag, ".excl"},   int'(hit_pulse & miss_pulse), 0);
        hits_seen += int'(hit_pulse);
        miss_seen += int'(miss_pulse);
    endtask

    task automatic step(input string tag, input int v, input int y, input int k);
        @(negedge Clk);
        note_valid = v[0];
        note_y_pos = y[9:0];
        key_press  = k[0];
        @(posedge Clk);
        model_edge(v, y, k);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        #2;
        model_reset();
        compare_all("reset");
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // A full note lifecycle with a strum at y; the pulse lands two edges after the key edge.
    task automatic strum_note(input string tag, input int y);
        step(tag, 0, 0, 0);
        step(tag, 1, y, 0);
        step(tag, 1, y, 1);
        step(tag, 1, y, 0);
        step(tag, 1, y, 0);
        step(tag, 1, y, 0);
        step(tag, 0, 0, 0);
    endtask

    initial begin
        Reset      = 1'b1;
        note_valid = 1'b0;
        note_y_pos = 10'd0;
        key_press  = 1'b0;
        hits_seen  = 0;
        miss_seen  = 0;
        model_reset();
        #5;
        compare_all("por");
        do_reset();

        // Centred hit, then a second strum while the note is still valid is ignored.
        hits_seen = 0;
        step("centre", 1, 400, 0);
        step("centre", 1, 400, 1);
        step("centre", 1, 400, 0);
        step("centre", 1, 400, 0);
        check("centre.pulse_at_k2", int'(hit_pulse), 1);
        step("centre", 1, 400, 0);
        step("centre", 1, 400, 1);
        step("centre", 1, 400, 0);
        step("centre", 1, 400, 0);
        step("centre", 1, 400, 0);
        check("centre.one_hit", hits_seen, 1);
        check("centre.score", int'(score), 10);
        check("centre.streak", int'(streak), 1);
        step("centre", 0, 0, 0);

        // Early strum, then a repeat strum on the judged note.
        miss_seen = 0;
        strum_note("early", 380);
        step("early2", 1, 380, 0);
        step("early2", 1, 380, 1);
        step("early2", 1, 380, 0);
        step("early2", 1, 380, 0);
        step("early2", 1, 380, 0);
        check("early.streak", int'(streak), 0);
        check("early.score", int'(score), 10);

        // Late miss without any key: exactly one pulse.
        step("late", 0, 0, 0);
        miss_seen = 0;
        step("late", 1, 400, 0);
        step("late", 1, 410, 0);
        step("late", 1, 413, 0);
        check("late.pulse", int'(miss_pulse), 1);
        step("late", 1, 416, 0);
        step("late", 1, 420, 0);
        check("late.once", miss_seen, 1);

        // Window edges and note_valid dropping with the key rise.
        strum_note("edge_lo", 388);
        check("edge_lo.streak", int'(streak), 1);
        strum_note("edge_hi", 412);
        check("edge_hi.streak", int'(streak), 2);
        strum_note("edge_out", 413);
        hits_seen = 0;
        miss_seen = 0;
        step("prio", 1, 400, 0);
        step("prio", 1, 400, 1);
        step("prio", 1, 400, 0);
        step("prio", 0, 400, 0);
        step("prio", 0, 400, 0);
        step("prio", 1, 430, 0);
        check("prio.no_pulse", hits_seen + miss_seen, 0);
        step("prio", 0, 0, 0);

        // Streak multiplier around the tenth hit.
        do_reset();
        for (int i = 0; i < 10; i++) strum_note("mult", 400);
        check("mult.score10", int'(score), 100);
        strum_note("mult", 400);
`ifdef JUDGE_STREAK_MULT_EN
        check("mult.score11", int'(score), 120);
`else
        check("mult.score11", int'(score), 110);
`endif

        // Asynchronous reset while tracking with score 30 / streak 3.
        do_reset();
        for (int i = 0; i < 3; i++) strum_note("pre_rst", 400);
        step("pre_rst", 1, 400, 0);
        step("pre_rst", 1, 400, 1);
        step("pre_rst", 1, 400, 0);
        @(negedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge Clk);
        Reset = 1'b0;
        hits_seen = 0;
        miss_seen = 0;
        for (int i = 0; i < 4; i++) step("post_rst", 1, 400, 0);
        check("post_rst.quiet", hits_seen + miss_seen, 0);

        // Random play.
        for (int i = 0; i < 1500; i++) begin
            step("rand",
                 ($urandom_range(0, 9) != 0) ? 1 : 0,
                 int'($urandom_range(360, 470)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_hit_judge.md
# note_hit_judge

Per-lane hit judge for the falling-note game, and the consuming end of a note sprite's position output. It tracks the lane's note as it falls and watches the player's key for that lane. It then decides hit or miss against a fixed strike line and maintains score and streak counters. It also returns a one-cycle `note_clear` so the sprite can despawn a struck note.

## Interface
- `HIT_LINE`, 10'd440, screen Y of the strike line.
- `WINDOW`, 10'd12, half-width of the hit window in pixels. Must satisfy HIT_LINE ≥ WINDOW.
- `NOTE_SIZE`, 10'd40, note height in pixels. Matches the sprite size.
- `HIT_POINTS`, 16'd10, base points per hit.

- `Clk` in 1: 50 MHz system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `note_y_pos` in 10: top Y of the lane's note.
- `note_valid` in 1: note is on screen and falling. When 0, `note_y_pos` is ignored.
- `key_press` in 1: raw level from the keyboard decoder, asynchronous to the judge.
- `hit_pulse` out 1: one-cycle strobe on a hit.
- `miss_pulse` out 1: one-cycle strobe on a miss.
- `note_clear` out 1: one-cycle despawn request to the sprite. Coincident with `hit_pulse`.
- `score` out 16: accumulated score, saturating.
- `streak` out 8: consecutive hits, saturating.

## Operation
- Key path:
  - `key_press` passes through a 2-flop synchronizer (s1, s2) and then a history flop (prev).
  - `key_rise` = s2 & ~prev. Only rising edges are judged; holding the key does nothing further.
- Geometry:
  - bottom = {1'b0,note_y_pos} + NOTE_SIZE, computed at 11 bits with no wrap.
  - in_window = bottom ≥ HIT_LINE−WINDOW and bottom ≤ HIT_LINE+WINDOW.
  - late = bottom > HIT_LINE+WINDOW.
- FSM states: IDLE, TRACK, JUDGED.
  - IDLE → TRACK when note_valid=1 and late=0.
  - IDLE → JUDGED when note_valid=1 and late=1. No pulse is produced: a note that appears already past the line is not judged.
  - TRACK, note_valid=0 → IDLE, no pulse.
  - TRACK, key_rise and in_window → JUDGED: hit_pulse, note_clear, score += pts, streak += 1.
  - TRACK, key_rise and not in_window → JUDGED: miss_pulse, streak ← 0. This covers an early strum.
  - TRACK, no key_rise and late → JUDGED: miss_pulse, streak ← 0.
  - JUDGED → IDLE when note_valid=0. This handles the sprite wrap to y=0 and its motion=0 idle.
- In IDLE and JUDGED, key_rise is ignored with no penalty.
- Priority and simultaneous events:
  - note_valid=0 beats key_rise in the same cycle; the result is IDLE and no pulse.
  - key_rise beats the late check in the same cycle.
- Arithmetic:
  - score adds at 17 bits and clamps to 16'hFFFF.
  - streak clamps at 8'hFF.
  - pts = HIT_POINTS unless modified under Configuration.

## Timing
- Reset values:
  - state = IDLE.
  - s1, s2 and prev = 0.
  - hit_pulse, miss_pulse and note_clear = 0.
  - score = 0, streak = 0.
- Reset is asynchronous: a mid-TRACK assertion clears everything immediately, with no pulse emitted. The first judgement after reset requires a fresh note_valid rise through IDLE.
- Key latency: define edge k as the first Clk edge that samples key_press high. hit_pulse or miss_pulse is high for exactly one cycle following edge k+2.
- score and streak update on the same edge that raises the pulse. They are visible in the pulse cycle.
- Late-miss latency: miss_pulse rises on the Clk edge after note_y_pos first makes late=1, given state is TRACK.
- At most one judgement per note: hit_pulse and miss_pulse are never high together. Neither pulses twice before a return to IDLE.
- The sprite updates position only on frame edges. The judge evaluates every Clk, so key timing is resolved to roughly 3 Clk cycles, not to the frame.

## Configuration
- `JUDGE_STREAK_MULT_EN`
  - Defined: pts = HIT_POINTS<<1 when streak ≥ 10 before the increment. pts = HIT_POINTS<<2 when streak ≥ 30. Otherwise pts = HIT_POINTS. The shift is done at 17 bits before clamping.
  - Undefined: pts = HIT_POINTS always. The streak comparators are not synthesized.

## Test plan
- Centred hit:
  - Stimulus: note_valid=1, note_y_pos=400 (bottom 440), key_press pulsed.
  - Required: one hit_pulse and one note_clear at k+2, score=10, streak=1, state JUDGED.
- Early strum:
  - Stimulus: note_y_pos=380 (bottom 420 < 428), key_press.
  - Required: miss_pulse, streak=0, score unchanged. A second key_press before note_valid drops produces no pulse.
- Late miss:
  - Stimulus: note_y_pos steps 400→410→413 (bottom 453), no key.
  - Required: miss_pulse on the cycle after 413 appears, exactly once.
- Boundary and priority:
  - Stimulus: bottom=428 with key → hit. Bottom=452 with key → hit. note_valid drops in the same cycle as key_rise.
  - Required: the last case gives no pulse and IDLE.
- Multiplier:
  - Stimulus: 10 consecutive hits, then an 11th.
  - Required with `JUDGE_STREAK_MULT_EN`: score 100→120.
  - Required without it: score 100→110.
- Async reset mid-TRACK:
  - Stimulus: Reset asserted between Clk edges, with score=30 and streak=3.
  - Required: outputs read 0 before the next edge; no spurious pulse after release.
